// File: rtl/ssp_uart_host.sv
// ssp_uart_host: SSP frame master for the SSP_UART slave port.
// One register-access command per valid/ready handshake becomes one 16-bit
// SSP frame (3 address bits, 1 command bit, 12 data bits). The slave's read
// data is captured on the last frame cycle and returned on a response strobe.
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_FRAME | SSEL high, SCK running, 16 SCK periods
// S_GAP   | pGap idle cycles after a frame, rsp_valid in the first one
module ssp_uart_host #(
  parameter int pSCK_Div = 2,
  parameter int pGap     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_ra,
  input  logic        cmd_wnr,
  input  logic [11:0] cmd_di,
  output logic        rsp_valid,
  output logic [11:0] rsp_do,
  output logic        busy,
  output logic        SSP_SSEL,
  output logic        SSP_SCK,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic        SSP_En,
  output logic        SSP_EOC,
  output logic [11:0] SSP_DI,
  input  logic [11:0] SSP_DO
);

  if (pSCK_Div < 1) begin : g_div_chk
    $error("ssp_uart_host: pSCK_Div must be >= 1");
  end
  if (pGap < 1) begin : g_gap_chk
    $error("ssp_uart_host: pGap must be >= 1");
  end

  // A divider of 1 needs no half-period count; keep a 1-bit counter pinned at 0.
  localparam int HW = (pSCK_Div > 1) ? $clog2(pSCK_Div) : 1;
  localparam int GW = (pGap > 1) ? $clog2(pGap) : 1;
  localparam logic [HW-1:0] H_MAX = HW'(pSCK_Div - 1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [GW-1:0] G_MAX = GW'(pGap - 1);
  localparam logic [GW-1:0] G_ONE = GW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [11:0]   rsp_do_q, rsp_do_d;
  logic          ssel_q, ssel_d;
  logic          sck_q, sck_d;
  logic [2:0]    ra_q, ra_d;
  logic          wnr_q, wnr_d;
  logic          en_q, en_d;
  logic          eoc_q, eoc_d;
  logic [11:0]   di_q, di_d;

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    bitcnt_d    = bitcnt_q;
    gap_d       = gap_q;
    rsp_valid_d = 1'b0;
    rsp_do_d    = rsp_do_q;
    ssel_d      = ssel_q;
    sck_d       = sck_q;
    ra_d        = ra_q;
    wnr_d       = wnr_q;
    en_d        = en_q;
    eoc_d       = eoc_q;
    di_d        = di_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = S_FRAME;
          ra_d     = cmd_ra;
          wnr_d    = cmd_wnr;
          di_d     = cmd_wnr ? cmd_di : 12'd0;
          ssel_d   = 1'b1;
          sck_d    = 1'b0;
          en_d     = 1'b0;
          eoc_d    = 1'b0;
          bitcnt_d = 4'd15;
          hcnt_d   = '0;
        end
      end
      S_FRAME: begin
        if (hcnt_q == H_MAX) begin
          hcnt_d = '0;
          sck_d  = ~sck_q;
          if (sck_q) begin
            // Falling edge: either move to the next bit or close the frame.
            if (bitcnt_q == 4'd0) begin
              state_d     = S_GAP;
              ssel_d      = 1'b0;
              sck_d       = 1'b0;
              en_d        = 1'b0;
              eoc_d       = 1'b0;
              rsp_valid_d = 1'b1;
              rsp_do_d    = wnr_q ? 12'd0 : SSP_DO;
              gap_d       = G_MAX;
            end else begin
              bitcnt_d = bitcnt_q - 4'd1;
              en_d     = (bitcnt_q <= 4'd12);
              eoc_d    = (bitcnt_q == 4'd1);
            end
          end
        end else begin
          hcnt_d = hcnt_q + H_ONE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - G_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything including cmd_ready.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      bitcnt_q    <= 4'd0;
      gap_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_do_q    <= 12'd0;
      ssel_q      <= 1'b0;
      sck_q       <= 1'b0;
      ra_q        <= 3'd0;
      wnr_q       <= 1'b0;
      en_q        <= 1'b0;
      eoc_q       <= 1'b0;
      di_q        <= 12'd0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      bitcnt_q    <= bitcnt_d;
      gap_q       <= gap_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_do_q    <= rsp_do_d;
      ssel_q      <= ssel_d;
      sck_q       <= sck_d;
      ra_q        <= ra_d;
      wnr_q       <= wnr_d;
      en_q        <= en_d;
      eoc_q       <= eoc_d;
      di_q        <= di_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_do    = rsp_do_q;
  assign SSP_SSEL  = ssel_q;
  assign SSP_SCK   = sck_q;
  assign SSP_RA    = ra_q;
  assign SSP_WnR   = wnr_q;
  assign SSP_En    = en_q;
  assign SSP_EOC   = eoc_q;
  assign SSP_DI    = di_q;

endmodule

// File: tb/tb_ssp_uart_host.sv
// Directed bench for ssp_uart_host: pSCK_Div=2/pGap=2 main instance plus a
// pSCK_Div=1 instance for the fast-clock frame timing.
module tb_ssp_uart_host;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_ra = 3'd0;
  logic        cmd_wnr = 1'b0;
  logic [11:0] cmd_di = 12'd0;
  logic        rsp_valid;
  logic [11:0] rsp_do;
  logic        busy;
  logic        SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC;
  logic [2:0]  SSP_RA;
  logic [11:0] SSP_DI;
  logic [11:0] SSP_DO = 12'd0;

  logic        c1_valid = 1'b0;
  logic        c1_ready;
  logic [2:0]  c1_ra = 3'd0;
  logic        c1_wnr = 1'b0;
  logic [11:0] c1_di = 12'd0;
  logic        r1_valid;
  logic [11:0] r1_do;
  logic        busy_1;
  logic        ssel_1, sck_1, wnr_1, en_1, eoc_1;
  logic [2:0]  ra_1;
  logic [11:0] di_1;
  logic [11:0] do_1 = 12'd0;

  int n_cmp = 0;
  int n_mis = 0;
  logic [11:0] prev_do = 12'd0;

  always #5 Clk = ~Clk;

  ssp_uart_host #(.pSCK_Div(2), .pGap(2)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ra(cmd_ra),
    .cmd_wnr(cmd_wnr), .cmd_di(cmd_di),
    .rsp_valid(rsp_valid), .rsp_do(rsp_do), .busy(busy),
    .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
    .SSP_En(SSP_En), .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
  );

  ssp_uart_host #(.pSCK_Div(1), .pGap(2)) u_dut1 (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ra(c1_ra),
    .cmd_wnr(c1_wnr), .cmd_di(c1_di),
    .rsp_valid(r1_valid), .rsp_do(r1_do), .busy(busy_1),
    .SSP_SSEL(ssel_1), .SSP_SCK(sck_1), .SSP_RA(ra_1), .SSP_WnR(wnr_1),
    .SSP_En(en_1), .SSP_EOC(eoc_1), .SSP_DI(di_1), .SSP_DO(do_1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issues one command on the main instance from the current cycle T and checks
  // cycles T+1..T+67. With keep=1 cmd_valid stays high carrying the next command.
  task automatic run_frame(input logic [2:0] ra, input logic wnr, input logic [11:0] di,
                           input logic [11:0] do_val, input logic keep,
                           input logic [2:0] ra_n, input logic wnr_n, input logic [11:0] di_n);
    logic [11:0] exp_do;
    logic [11:0] exp_di;
    exp_do = wnr ? 12'd0 : do_val;
    exp_di = wnr ? di : 12'd0;
    check("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ra = ra;
    cmd_wnr = wnr;
    cmd_di = di;
    SSP_DO = ~do_val;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 1) begin
        if (keep) begin
          cmd_ra = ra_n;
          cmd_wnr = wnr_n;
          cmd_di = di_n;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      SSP_DO = (k >= 61 && k <= 64) ? do_val : ~do_val;
      check($sformatf("ssel_k%0d", k), SSP_SSEL, (k <= 64));
      check($sformatf("sck_k%0d", k), SSP_SCK, (k <= 64) && (((k - 1) / 2) % 2 == 1));
      check($sformatf("en_k%0d", k), SSP_En, (k >= 17 && k <= 64));
      check($sformatf("eoc_k%0d", k), SSP_EOC, (k >= 61 && k <= 64));
      check($sformatf("rsp_valid_k%0d", k), rsp_valid, (k == 65));
      check($sformatf("rsp_do_k%0d", k), rsp_do, (k < 65) ? prev_do : exp_do);
      check($sformatf("ready_k%0d", k), cmd_ready, 0);
      check($sformatf("busy_k%0d", k), busy, 1);
      check($sformatf("ra_k%0d", k), SSP_RA, ra);
      check($sformatf("wnr_k%0d", k), SSP_WnR, wnr);
      check($sformatf("di_k%0d", k), SSP_DI, exp_di);
    end
    prev_do = exp_do;
    tick();
    check("ready_k67", cmd_ready, 1);
    check("busy_k67", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held for three cycles, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_ssp_%0d", i),
            {SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI}, 0);
      check($sformatf("rst_host_%0d", i), {cmd_ready, rsp_valid, busy, rsp_do}, 0);
      check($sformatf("rst_fast_%0d", i), {c1_ready, ssel_1, sck_1, r1_valid}, 0);
    end
    Rst = 1'b1;
    tick();
    check("rel_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_ready_fast", c1_ready, 1);

    // 2: write ra=3 di=0xA5C
    run_frame(3'd3, 1'b1, 12'hA5C, 12'h123, 1'b0, 3'd0, 1'b0, 12'd0);
    // 3: read ra=5, slave returns 0x3F1 during bit 0; write data must be dropped
    run_frame(3'd5, 1'b0, 12'h777, 12'h3F1, 1'b0, 3'd0, 1'b0, 12'd0);
    // 4: cmd_valid held across two commands; second accepted at T+67
    run_frame(3'd1, 1'b1, 12'h0F0, 12'h555, 1'b1, 3'd6, 1'b0, 12'h000);
    run_frame(3'd6, 1'b0, 12'h000, 12'hC3A, 1'b0, 3'd0, 1'b0, 12'd0);

    // 5: reset at T+20 aborts the frame
    check("abort_accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ra = 3'd2;
    cmd_wnr = 1'b1;
    cmd_di = 12'h111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) cmd_valid = 1'b0;
    end
    check("abort_ssel_pre", SSP_SSEL, 1);
    Rst = 1'b0;
    tick();
    check("abort_ssel", SSP_SSEL, 0);
    check("abort_sck", SSP_SCK, 0);
    check("abort_en", SSP_En, 0);
    check("abort_eoc", SSP_EOC, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_do", rsp_do, 0);
    check("abort_ra_di", {SSP_RA, SSP_WnR, SSP_DI}, 0);
    check("abort_ready_busy", {cmd_ready, busy}, 0);
    Rst = 1'b1;
    prev_do = 12'd0;
    for (int k = 0; k < 60; k++) begin
      tick();
      check($sformatf("abort_no_rsp_%0d", k), rsp_valid, 0);
    end
    run_frame(3'd4, 1'b1, 12'hBEE, 12'h0AA, 1'b0, 3'd0, 1'b0, 12'd0);

    // 6: pSCK_Div=1 instance, read ra=7
    check("fast_accept_ready", c1_ready, 1);
    c1_valid = 1'b1;
    c1_ra = 3'd7;
    c1_wnr = 1'b0;
    c1_di = 12'h000;
    do_1 = 12'hF3C;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 1) c1_valid = 1'b0;
      do_1 = (k >= 31 && k <= 32) ? 12'h0C3 : 12'hF3C;
      check($sformatf("fast_ssel_k%0d", k), ssel_1, (k <= 32));
      check($sformatf("fast_sck_k%0d", k), sck_1, (k <= 32) && (k % 2 == 0));
      check($sformatf("fast_en_k%0d", k), en_1, (k >= 9 && k <= 32));
      check($sformatf("fast_eoc_k%0d", k), eoc_1, (k >= 31 && k <= 32));
      check($sformatf("fast_rsp_valid_k%0d", k), r1_valid, (k == 33));
      check($sformatf("fast_ready_k%0d", k), c1_ready, (k == 35));
      if (k >= 33) check($sformatf("fast_rsp_do_k%0d", k), r1_do, 12'h0C3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
